alu_serial: RTL and testbench

//  Parametrised bit-serial ALU: NOR, XOR, ADD and SUB on WIDTH-bit operands.

---
 rtl/alu_serial_if.sv | 30 +++
 rtl/alu_serial.sv | 114 +++++++++++
 tb/tb_alu_serial.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_if.sv
// Operand/result bus of the bit-serial ALU: request channel (a, b, op) and
// response channel (result plus status flags).
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; the source holds its payload stable while
// valid is high and ready is low.
interface alu_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, cout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, cout, zero, ovf
    );
endinterface

// File: rtl/alu_serial.sv
// Bit-serial NOR/XOR/ADD/SUB ALU: one 1-bit slice plus a carry register,
// stepped LSB-first, one operand bit per clock.
module alu_serial #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_serial_if.slave bus,
    output logic [1:0] dbg_state_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FIN_CNT  = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             alive_q;
    logic [WIDTH-1:0] a_q, b_q, sh_q, result_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cmsb_q;
    logic             out_valid_q, cout_q, zero_q, ovf_q;

    logic accept, arith, b_bit, s_bit, c_next;

    // alive_q keeps in_ready low while reset is asserted.
    assign bus.in_ready = alive_q & ((state_q == IDLE) |
                                     ((state_q == DONE) & bus.out_ready));
    assign accept       = bus.in_valid & bus.in_ready;
    assign arith        = op_q[1];
    assign b_bit        = b_q[0] ^ (op_q == 2'b11);
    assign c_next       = (a_q[0] & b_bit) | (carry_q & (a_q[0] ^ b_bit));

    always_comb begin
        s_bit = 1'b0;
        case (op_q)
            2'b00:   s_bit = ~(a_q[0] | b_q[0]);
            2'b01:   s_bit = a_q[0] ^ b_q[0];
            default: s_bit = a_q[0] ^ b_bit ^ carry_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alive_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sh_q        <= '0;
            result_q    <= '0;
            op_q        <= 2'b00;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cmsb_q      <= 1'b0;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (accept) begin
                a_q         <= bus.a;
                b_q         <= bus.b;
                op_q        <= bus.op;
                sh_q        <= '0;
                cnt_q       <= '0;
                carry_q     <= (bus.op == 2'b11);
                cmsb_q      <= 1'b0;
                out_valid_q <= 1'b0;
                state_q     <= RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        if (cnt_q == FIN_CNT) begin
                            // All bits shifted in: publish result and flags together.
                            result_q    <= sh_q;
                            zero_q      <= (sh_q == '0);
                            cout_q      <= arith & carry_q;
                            ovf_q       <= arith & (cmsb_q ^ carry_q);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            sh_q  <= {s_bit, sh_q[WIDTH-1:1]};
                            a_q   <= a_q >> 1;
                            b_q   <= b_q >> 1;
                            cnt_q <= cnt_q + CW'(1);
                            if (arith) carry_q <= c_next;
                            if (cnt_q == LAST_BIT) cmsb_q <= carry_q;
                        end
                    end
                    DONE: begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial (WIDTH=8): directed vector table, handshake corner
// sequences and randomized operations against an arithmetic reference model.
module tb_alu_serial;
    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         total;
    int         bad;

    alu_serial_if #(.WIDTH(W)) bus ();

    alu_serial #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         ovf;
    } ref_t;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         ovf;
    } vec_t;

    // scoreboard: expected results of accepted operations, in order
    logic [W+2:0] exp_q[$];

    function automatic ref_t ref_calc(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        ref_t r;
        logic [W:0] wide;
        r = '0;
        case (op)
            2'b00: r.res = ~(a | b);
            2'b01: r.res = a ^ b;
            2'b10: begin
                wide   = {1'b0, a} + {1'b0, b};
                r.res  = wide[W-1:0];
                r.cout = wide[W];
                r.ovf  = (a[W-1] == b[W-1]) && (r.res[W-1] != a[W-1]);
            end
            default: begin
                wide   = {1'b0, a} + {1'b0, ~b} + 1;
                r.res  = wide[W-1:0];
                r.cout = wide[W];
                r.ovf  = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]);
            end
        endcase
        r.zero = (r.res == '0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: wait for in_ready, transfer one operation, scramble the inputs after
    task automatic send_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        #1;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = 2'($urandom);
        bus.a  = W'($urandom);
        bus.b  = W'($urandom);
        exp_q.push_back({ref_calc(op, a, b)});
    endtask

    // called one sample point after the accepting edge; returns cycles to out_valid
    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_result(input string tag);
        ref_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 64'(bus.result), 64'(e.res));
            check({tag, "_cout"},   64'(bus.cout),   64'(e.cout));
            check({tag, "_zero"},   64'(bus.zero),   64'(e.zero));
            check({tag, "_ovf"},    64'(bus.ovf),    64'(e.ovf));
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_drop", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        vec_t   vecs[5];
        int     lat;
        ref_t   held;
        logic [1:0] rop;
        logic [W-1:0] ra, rb;
        int     dly;

        total = 0;
        bad   = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a  = '0;
        bus.b  = '0;
        bus.op = 2'b00;
        rst_n  = 1'b0;

        vecs[0] = '{"add_ff_01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{"sub_80_01", 2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{"sub_00_01", 2'b11, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{"nor_0f_30", 2'b00, 8'h0F, 8'h30, 8'hC0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"xor_a5_a5", 2'b01, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0};

        // reset values while rst_n is low
        #3;
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result",    64'(bus.result),    64'd0);
        check("rst_flags",     64'({bus.cout, bus.zero, bus.ovf}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // directed table
        for (int i = 0; i < 5; i++) begin
            send_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_out(lat);
            check({vecs[i].name, "_lat"},    64'(lat),            64'd9);
            check({vecs[i].name, "_result"}, 64'(bus.result),     64'(vecs[i].res));
            check({vecs[i].name, "_cout"},   64'(bus.cout),       64'(vecs[i].cout));
            check({vecs[i].name, "_zero"},   64'(bus.zero),       64'(vecs[i].zero));
            check({vecs[i].name, "_ovf"},    64'(bus.ovf),        64'(vecs[i].ovf));
            void'(exp_q.pop_front());
            drain();
        end

        // backpressure in DONE, then same-edge turnaround into a new ADD
        send_op(2'b10, 8'h33, 8'h44);
        wait_out(lat);
        held = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = $urandom_range(0, 1);
            bus.a  = W'($urandom);
            bus.b  = W'($urandom);
            bus.op = 2'($urandom);
            #1;
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_result",    64'(bus.result),    64'(held.res));
            check("bp_flags",     64'({bus.cout, bus.zero, bus.ovf}),
                                  64'({held.cout, held.zero, held.ovf}));
            @(posedge clk); #1;
        end
        check_result("bp_final");
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op = 2'b10;
        bus.a  = 8'h01;
        bus.b  = 8'h02;
        #1;
        check("turn_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = 8'hEE;
        bus.b = 8'hEE;
        exp_q.push_back({ref_calc(2'b10, 8'h01, 8'h02)});
        check("turn_out_valid_drop", 64'(bus.out_valid), 64'd0);
        check("turn_state_run",      64'(dbg_state),     64'd1);
        wait_out(lat);
        check("turn_lat", 64'(lat), 64'd9);
        check("turn_result_03", 64'(bus.result), 64'h03);
        check_result("turn");
        drain();

        // reset in the middle of RUN (after bits 0..3 processed)
        send_op(2'b10, 8'h5A, 8'h11);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_result",    64'(bus.result),    64'd0);
        check("midrst_in_ready",  64'(bus.in_ready),  64'd0);
        check("midrst_state",     64'(dbg_state),     64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready_after", 64'(bus.in_ready), 64'd1);
        send_op(2'b10, 8'h10, 8'h20);
        wait_out(lat);
        check("midrst_next_30", 64'(bus.result), 64'h30);
        check_result("midrst_next");
        drain();

        // randomized operations with random consumer delay
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = W'($urandom);
            rb  = W'($urandom);
            send_op(rop, ra, rb);
            wait_out(lat);
            check("rnd_lat", 64'(lat), 64'd9);
            dly = $urandom_range(0, 3);
            repeat (dly) begin
                @(posedge clk); #1;
            end
            check("rnd_hold_valid", 64'(bus.out_valid), 64'd1);
            check_result("rnd");
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end
endmodule
